tmds_encoder: RTL and testbench
===============================

Name: tmds_encoder

Overview:
- DVI/TMDS 8b/10b encoder for three channels. Sits directly downstream of the 640x480 video timing/pattern generator.
- Consumes its registered DrawArea, hSync and vSync outputs and its 8-bit red/green/blue outputs, all on the same pixel clock.
- Produces three 10-bit TMDS words per pixel, DC-balanced per the DVI 1.0 algorithm, for an external 10:1 serializer.

Parameters:
- CNT_W, 5, width of each channel's signed running-disparity counter (two's complement, range -16..+15).

Ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- DrawArea  input  1  1 = active video (data period), 0 = control period
- hSync  input  1  horizontal sync, carried as C0 on the blue channel
- vSync  input  1  vertical sync, carried as C1 on the blue channel
- red  input  8  pixel red
- green  input  8  pixel green
- blue  input  8  pixel blue
- TMDS_red  output  10  encoded red channel word, bit 0 transmitted first
- TMDS_green  output  10  encoded green channel word
- TMDS_blue  output  10  encoded blue channel word

Behaviour:
- Three identical channel encoders. Blue control input is {C1,C0}={vSync,hSync}; green and red control inputs are 2'b00.
- Stage 1 (registered), transition minimisation:
  - N1(D) is the ones count of the input byte D.
  - If N1(D)>4, or N1(D)==4 and D[0]==0: XNOR chain. q_m[0]=D[0]; q_m[i]=~(q_m[i-1]^D[i]); q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - DrawArea, hSync and vSync are delayed alongside q_m.
- Stage 2 (registered), DC balance. n1/n0 are the ones/zeros counts of q_m[7:0]; cnt is the signed disparity.
  - Case A, cnt==0 or n1==n0: out={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}. cnt += q_m[8]?(n1-n0):(n0-n1).
  - Case B, (cnt>0 and n1>n0) or (cnt<0 and n0>n1): out={1, q_m[8], ~q_m[7:0]}. cnt += 2*q_m[8]+(n0-n1).
  - Case C, otherwise: out={0, q_m[8], q_m[7:0]}. cnt += (n1-n0)-2*(~q_m[8]).
  - All disparity arithmetic is signed CNT_W-bit. The algorithm bounds |cnt|<=10, so no saturation is needed.
- Control period (delayed DrawArea==0): the output is the fixed token and cnt is forced to 0.
  - {C1,C0}=00 -> 10'b1101010100
  - 01 -> 10'b0010101011
  - 10 -> 10'b0101010100
  - 11 -> 10'b1010101011
- Latency: 2 clk from input to TMDS_* output. Throughput: one word per clock, no stalls, no handshake.
- Reset, asynchronous:
  - All TMDS_* outputs go to 10'b1101010100.
  - All cnt go to 0.
  - Stage-1 registers clear, with DrawArea delay=0.
  - Reset asserted mid-line takes effect immediately. After release, the first valid output appears 2 clk after the first sampled input.
- Data->control boundary: the first control word is emitted exactly 2 clk after DrawArea falls, and cnt is 0 from that cycle.
- Control->data boundary: the first data word is encoded from cnt=0.
- Syncs are ignored during data periods and only appear via tokens.

Optional Feature:
- Macro: TMDS_PIPE_EN.
- Defined: an extra register stage holds q_m together with its precomputed n1/n0 and (n1-n0) before the balance stage. This shortens the critical path for high pixel clocks. Latency becomes 3 clk, and DrawArea/hSync/vSync are delayed by 3 to match.
- Undefined: n1/n0 are computed combinationally in stage 2, and latency is 2 clk.
- Encoded values and every other behaviour are identical in both configurations.

Test Plan:
- Assert reset for 3 clk with random inputs -> all three TMDS_* == 10'b1101010100 throughout reset and for 2 clk after release while DrawArea=0, hSync=0, vSync=0.
- DrawArea=0, hSync=1, vSync=0 -> after 2 clk TMDS_blue=10'b0010101011 and TMDS_red=TMDS_green=10'b1101010100. Then vSync=1, hSync=1 -> TMDS_blue=10'b1010101011.
- From control, DrawArea=1 and blue=8'h00 for 2 clk -> TMDS_blue=10'b0100000000 (cnt=-8), then 10'b1111111111 (cnt=+2).
- From control, DrawArea=1 and green=8'hFF for 1 clk -> TMDS_green=10'b1000000000 with cnt=-8. Compare each channel against a software reference model over 640 random pixels and check |cnt|<=10 on every cycle.
- Data->control transition after a random line, then a new line -> the first control token lands exactly 2 clk after DrawArea falls. The new line's first word matches the model run from cnt=0.
- Assert reset asynchronously mid-line (between clock edges) -> outputs switch to 10'b1101010100 before the next edge. The post-reset line matches the model from cnt=0. Repeat with TMDS_PIPE_EN defined and a 3-clk latency check.

Source files
------------

// File: rtl/tmds_encoder.sv
// tmds_encoder: three-channel DVI 8b/10b TMDS encoder (red, green, blue).
// Stage 1 minimises transitions. Stage 2 balances DC using a signed
// running disparity per channel and inserts control tokens outside active video.
// Optional macro TMDS_PIPE_EN adds a register stage between the two stages.
// That stage holds q_m and its precomputed disparity (n1-n0), and latency
// becomes 3 clk instead of 2.
module tmds_encoder #(
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DrawArea,
  input  logic       hSync,
  input  logic       vSync,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [9:0] TMDS_red,
  output logic [9:0] TMDS_green,
  output logic [9:0] TMDS_blue
);

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // n1 - n0 of a byte, which equals 2*n1 - 8.
  function automatic logic signed [CNT_W-1:0] disparity(input logic [7:0] v);
    return CNT_W'({ones8(v), 1'b0}) - CNT_W'(8);
  endfunction

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'b00:   return TOKEN_00;
      2'b01:   return TOKEN_01;
      2'b10:   return TOKEN_10;
      default: return TOKEN_11;
    endcase
  endfunction

  // Channel index 0 = red, 1 = green, 2 = blue.
  logic [2:0][7:0] pix;
  logic [2:0][9:0] word;
  assign pix = {blue, green, red};

  logic de_d1, hs_d1, vs_d1;
  logic de_bal, hs_bal, vs_bal;

  // Delay the timing signals alongside q_m in stage 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_d1 <= 1'b0;
      hs_d1 <= 1'b0;
      vs_d1 <= 1'b0;
    end else begin
      de_d1 <= DrawArea;
      hs_d1 <= hSync;
      vs_d1 <= vSync;
    end
  end

`ifdef TMDS_PIPE_EN
  logic de_d2, hs_d2, vs_d2;

  // Delay the timing signals one more clock to match the extra q_m stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_d2 <= 1'b0;
      hs_d2 <= 1'b0;
      vs_d2 <= 1'b0;
    end else begin
      de_d2 <= de_d1;
      hs_d2 <= hs_d1;
      vs_d2 <= vs_d1;
    end
  end

  assign de_bal = de_d2;
  assign hs_bal = hs_d2;
  assign vs_bal = vs_d2;
`else
  assign de_bal = de_d1;
  assign hs_bal = hs_d1;
  assign vs_bal = vs_d1;
`endif

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [8:0] qm_next, qm_reg, qm_bal;
    logic signed [CNT_W-1:0] diff_bal, cnt_reg, cnt_next;
    logic [9:0] word_reg, word_next;
    logic [1:0] ctrl;

    // Only the blue channel carries the syncs; the other channels send C=00.
    assign ctrl = (gi == 2) ? {vs_bal, hs_bal} : 2'b00;

    // Transition minimisation: choose the XNOR or XOR chain from the byte's ones count.
    always_comb begin : stage1_comb
      logic [3:0] n1_d;
      logic       use_xnor;
      n1_d     = ones8(pix[gi]);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !pix[gi][0]);
      qm_next    = '0;
      qm_next[0] = pix[gi][0];
      for (int i = 1; i < 8; i++)
        qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ pix[gi][i]) : (qm_next[i-1] ^ pix[gi][i]);
      qm_next[8] = ~use_xnor;
    end

    // Stage-1 register for the minimised word.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) qm_reg <= '0;
      else       qm_reg <= qm_next;
    end

`ifdef TMDS_PIPE_EN
    logic [8:0]              qm_p_reg;
    logic signed [CNT_W-1:0] diff_p_reg;

    // Extra stage: n1/n0 reach the balance logic only as their difference,
    // so only (n1-n0) is precomputed and registered here.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        qm_p_reg   <= '0;
        diff_p_reg <= '0;
      end else begin
        qm_p_reg   <= qm_reg;
        diff_p_reg <= disparity(qm_reg[7:0]);
      end
    end

    assign qm_bal   = qm_p_reg;
    assign diff_bal = diff_p_reg;
`else
    assign qm_bal   = qm_reg;
    assign diff_bal = disparity(qm_reg[7:0]);
`endif

    // DC balance: pick the inversion that steers the running disparity back to zero.
    always_comb begin : balance_comb
      logic signed [CNT_W-1:0] two_q8, two_nq8;
      logic cnt_pos, cnt_neg, more_ones, more_zeros;
      word_next  = TOKEN_00;
      cnt_next   = '0;
      two_q8     = qm_bal[8] ? CNT_W'(2) : '0;
      two_nq8    = qm_bal[8] ? '0 : CNT_W'(2);
      cnt_neg    = cnt_reg[CNT_W-1];
      cnt_pos    = !cnt_reg[CNT_W-1] && (cnt_reg != '0);
      more_zeros = diff_bal[CNT_W-1];
      more_ones  = !diff_bal[CNT_W-1] && (diff_bal != '0);
      if (!de_bal) begin
        word_next = token(ctrl);
        cnt_next  = '0;
      end else if ((cnt_reg == '0) || (diff_bal == '0)) begin
        word_next = {~qm_bal[8], qm_bal[8], qm_bal[8] ? qm_bal[7:0] : ~qm_bal[7:0]};
        cnt_next  = qm_bal[8] ? (cnt_reg + diff_bal) : (cnt_reg - diff_bal);
      end else if ((cnt_pos && more_ones) || (cnt_neg && more_zeros)) begin
        word_next = {1'b1, qm_bal[8], ~qm_bal[7:0]};
        cnt_next  = cnt_reg + two_q8 - diff_bal;
      end else begin
        word_next = {1'b0, qm_bal[8], qm_bal[7:0]};
        cnt_next  = cnt_reg + diff_bal - two_nq8;
      end
    end

    // Stage-2 register: output word and running disparity.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_reg <= TOKEN_00;
        cnt_reg  <= '0;
      end else begin
        word_reg <= word_next;
        cnt_reg  <= cnt_next;
      end
    end

    assign word[gi] = word_reg;
  end

  assign TMDS_red   = word[0];
  assign TMDS_green = word[1];
  assign TMDS_blue  = word[2];

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: table vectors plus random lines checked against a reference model.
module tb_tmds_encoder;

`ifdef TMDS_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic DrawArea = 1'b0, hSync = 1'b0, vSync = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic [9:0] TMDS_red, TMDS_green, TMDS_blue;

  tmds_encoder #(.CNT_W(5)) dut (
    .clk(clk), .reset(reset), .DrawArea(DrawArea), .hSync(hSync), .vSync(vSync),
    .red(red), .green(green), .blue(blue),
    .TMDS_red(TMDS_red), .TMDS_green(TMDS_green), .TMDS_blue(TMDS_blue)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic de, hs, vs;
    logic [7:0] r, g, b;
    logic [29:0] e;
    string n;
  } vec_t;

  typedef struct {
    bit v;
    logic [29:0] e;
    string n;
  } tv_t;

  vec_t vecs[10];
  logic [29:0] exp_q[$];
  tv_t tq[$];
  int mcnt[3];
  int max_abs = 0;
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return T00;
      2'b01:   return T01;
      2'b10:   return T10;
      default: return T11;
    endcase
  endfunction

  // Reference: q_m bit i is the parity of d[0..i]; the XNOR variant
  // additionally inverts every odd-indexed bit.
  function automatic logic [9:0] model_ch(input int ch, input logic de,
                                          input logic [1:0] c, input logic [7:0] d);
    logic [8:0] q;
    logic [9:0] w;
    bit p, xn;
    int ones, n1, n0, cnt;
    if (!de) begin
      mcnt[ch] = 0;
      return tok(c);
    end
    ones = $countones(d);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p ^= d[i];
      q[i] = (xn && (i % 2 == 1)) ? ~p : p;
    end
    q[8] = ~xn;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    cnt = mcnt[ch];
    if (cnt == 0 || n1 == n0) begin
      w = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cnt += q[8] ? (n1 - n0) : (n0 - n1);
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      w = {1'b1, q[8], ~q[7:0]};
      cnt += (q[8] ? 2 : 0) + n0 - n1;
    end else begin
      w = {1'b0, q[8], q[7:0]};
      cnt += n1 - n0 - (q[8] ? 0 : 2);
    end
    mcnt[ch] = cnt;
    if (cnt > max_abs) max_abs = cnt;
    if (-cnt > max_abs) max_abs = -cnt;
    return w;
  endfunction

  // After reset the pipeline registers hold the C=00 token.
  task automatic mreset();
    tv_t t;
    t.v = 1'b0;
    t.e = '0;
    t.n = "";
    for (int c = 0; c < 3; c++) mcnt[c] = 0;
    exp_q.delete();
    tq.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      exp_q.push_back({T00, T00, T00});
      tq.push_back(t);
    end
  endtask

  // Apply one pixel before the next edge, then compare the word due after that edge.
  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input bit tv, input logic [29:0] texp, input string tname);
    logic [29:0] e;
    tv_t t;
    DrawArea = de; hSync = hs; vSync = vs;
    red = r; green = g; blue = b;
    e = {model_ch(0, de, 2'b00, r), model_ch(1, de, 2'b00, g), model_ch(2, de, {vs, hs}, b)};
    exp_q.push_back(e);
    t.v = tv;
    t.e = texp;
    t.n = tname;
    tq.push_back(t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("model_red", TMDS_red, e[29:20]);
    chk("model_green", TMDS_green, e[19:10]);
    chk("model_blue", TMDS_blue, e[9:0]);
    t = tq.pop_front();
    if (t.v) begin
      chk({t.n, "_red"}, TMDS_red, t.e[29:20]);
      chk({t.n, "_green"}, TMDS_green, t.e[19:10]);
      chk({t.n, "_blue"}, TMDS_blue, t.e[9:0]);
    end
  endtask

  task automatic rstep(input logic de);
    step(de, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, '0, "");
  endtask

  // Assert reset between edges, check it acts at once, hold it, release mid-cycle.
  task automatic do_reset(input string name);
    #2;
    reset = 1'b1;
    DrawArea = 1'($urandom); hSync = 1'($urandom); vSync = 1'($urandom);
    red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
    #1;
    chk({name, "_async_red"}, TMDS_red, T00);
    chk({name, "_async_green"}, TMDS_green, T00);
    chk({name, "_async_blue"}, TMDS_blue, T00);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk({name, "_hold_red"}, TMDS_red, T00);
      chk({name, "_hold_green"}, TMDS_green, T00);
      chk({name, "_hold_blue"}, TMDS_blue, T00);
    end
    #2;
    reset = 1'b0;
    mreset();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h3C, 8'hC3, 8'h5A, {T00, T00, T00}, "post_reset_a"};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h81, {T00, T00, T00}, "post_reset_b"};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56, {T00, T00, T01}, "hsync_tok"};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56, {T00, T00, T11}, "hvsync_tok"};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 8'h56, {T00, T00, T10}, "vsync_tok"};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00,
                {10'b0100000000, 10'b1000000000, 10'b0100000000}, "data_first"};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00,
                {10'b1111111111, 10'b0011111111, 10'b1111111111}, "data_second"};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, {T00, T00, T00}, "data_to_ctrl"};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00,
                {10'b0100000000, 10'b1000000000, 10'b0100000000}, "ctrl_to_data"};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, {T00, T00, T01}, "hsync_again"};

    do_reset("reset0");

    for (int i = 0; i < 10; i++)
      step(vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].r, vecs[i].g, vecs[i].b,
           1'b1, vecs[i].e, vecs[i].n);

    // Full random line, blanking, then a new line starting from cnt=0.
    for (int i = 0; i < 640; i++) rstep(1'b1);
    for (int i = 0; i < 16; i++) rstep(1'b0);
    for (int i = 0; i < 100; i++) rstep(1'b1);

    // Reset mid-line, then continue the line straight after release.
    do_reset("reset_mid");
    for (int i = 0; i < 200; i++) rstep(1'b1);
    for (int i = 0; i < 4; i++) rstep(1'b0);

    checks++;
    if (max_abs <= 10) passed++;
    else $display("FAIL cnt_bound: got %0d expected <= 10", max_abs);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
